// File: rtl/video_timing_gen_pkg.sv
// Shared 720p raster constants and types for the timing generator and the
// sprite/encoder stages that consume its counters.
package video_timing_pkg;

  // 1280x720@60 geometry (pixels / lines)
  localparam int ACTIVE_H = 1280;
  localparam int H_FP     = 110;
  localparam int H_SYNC   = 40;
  localparam int H_BP     = 220;
  localparam int TOTAL_H  = ACTIVE_H + H_FP + H_SYNC + H_BP;  // 1650

  localparam int ACTIVE_V = 720;
  localparam int V_FP     = 5;
  localparam int V_SYNC   = 5;
  localparam int V_BP     = 20;
  localparam int TOTAL_V  = ACTIVE_V + V_FP + V_SYNC + V_BP;  // 750

  localparam int FPS      = 60;
  // Matches the downstream 4-cycle BRAM pipeline
  localparam int LATENCY  = 4;

  // Port widths of the timing bus
  localparam int HCOUNT_W = 11;
  localparam int VCOUNT_W = 10;
  localparam int FC_W     = 6;

  // Sync bundle carried through the delay pipe
  typedef struct packed {
    logic hs;
    logic vs;
    logic ad;
  } sync_bits_t;

endpackage

// File: rtl/video_timing_gen_if.sv
// Timing bus from the generator to the pixel pipeline. Pure broadcast:
// no handshake, every signal is valid on every pixel clock.
interface video_timing_gen_if;
  import video_timing_pkg::*;

  logic [HCOUNT_W-1:0] hcount_out;
  logic [VCOUNT_W-1:0] vcount_out;
  logic                hs_out;
  logic                vs_out;
  logic                ad_out;
  logic                nf_out;
  logic [FC_W-1:0]     fc_out;
  logic                hs_d_out;
  logic                vs_d_out;
  logic                ad_d_out;

  modport master (
    output hcount_out, vcount_out, hs_out, vs_out, ad_out, nf_out, fc_out,
           hs_d_out, vs_d_out, ad_d_out
  );

  modport slave (
    input  hcount_out, vcount_out, hs_out, vs_out, ad_out, nf_out, fc_out,
           hs_d_out, vs_d_out, ad_d_out
  );

endinterface

// File: rtl/video_timing_gen_sync_delay.sv
// Generic shift-register delay pipe with synchronous clear.
// q_o(t) = d_i(t-DEPTH); a clear zeroes every stage on the next edge.
module sync_delay #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] pipe_q [DEPTH];
  logic [WIDTH-1:0] pipe_d [DEPTH];

  // Next-state: stage 0 takes the input, every later stage takes its predecessor
  always_comb begin
    pipe_d[0] = d_i;
    for (int i = 1; i < DEPTH; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  // Stage registers, flushed on clear
  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        pipe_q[i] <= pipe_d[i];
      end
    end
  end

  assign q_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: pixel/line counters, sync/active decodes,
// new-frame strobe, frame counter, and LATENCY-delayed sync copies that
// stay aligned with the downstream BRAM lookup pipeline.
module video_timing_gen #(
  parameter int ACTIVE_H = video_timing_pkg::ACTIVE_H,
  parameter int H_FP     = video_timing_pkg::H_FP,
  parameter int H_SYNC   = video_timing_pkg::H_SYNC,
  parameter int H_BP     = video_timing_pkg::H_BP,
  parameter int ACTIVE_V = video_timing_pkg::ACTIVE_V,
  parameter int V_FP     = video_timing_pkg::V_FP,
  parameter int V_SYNC   = video_timing_pkg::V_SYNC,
  parameter int V_BP     = video_timing_pkg::V_BP,
  parameter int FPS      = video_timing_pkg::FPS,
  parameter int LATENCY  = video_timing_pkg::LATENCY
) (
  input  logic                pixel_clk_in,
  input  logic                rst_in,
  video_timing_gen_if.master  vid
);
  import video_timing_pkg::HCOUNT_W;
  import video_timing_pkg::VCOUNT_W;
  import video_timing_pkg::FC_W;
  import video_timing_pkg::sync_bits_t;

  localparam int TOTAL_H = ACTIVE_H + H_FP + H_SYNC + H_BP;
  localparam int TOTAL_V = ACTIVE_V + V_FP + V_SYNC + V_BP;

  // Parameter sanity, rejected at elaboration
  if (TOTAL_H > 2048 || TOTAL_V > 1024) begin : g_bad_geometry
    $error("video_timing_gen: TOTAL_H must be <= 2048 and TOTAL_V <= 1024");
  end
  if (LATENCY < 1 || LATENCY > 8) begin : g_bad_latency
    $error("video_timing_gen: LATENCY must be in 1..8");
  end
  if (FPS < 1 || FPS > 64) begin : g_bad_fps
    $error("video_timing_gen: FPS must be in 1..64");
  end

  // All decode thresholds at counter width
  localparam logic [HCOUNT_W-1:0] H_LAST   = HCOUNT_W'(TOTAL_H - 1);
  localparam logic [HCOUNT_W-1:0] H_ACT    = HCOUNT_W'(ACTIVE_H);
  localparam logic [HCOUNT_W-1:0] HS_START = HCOUNT_W'(ACTIVE_H + H_FP);
  localparam logic [HCOUNT_W-1:0] HS_END   = HCOUNT_W'(ACTIVE_H + H_FP + H_SYNC - 1);
  localparam logic [VCOUNT_W-1:0] V_LAST   = VCOUNT_W'(TOTAL_V - 1);
  localparam logic [VCOUNT_W-1:0] V_ACT    = VCOUNT_W'(ACTIVE_V);
  localparam logic [VCOUNT_W-1:0] VS_START = VCOUNT_W'(ACTIVE_V + V_FP);
  localparam logic [VCOUNT_W-1:0] VS_END   = VCOUNT_W'(ACTIVE_V + V_FP + V_SYNC - 1);
  localparam logic [FC_W-1:0]     FC_LAST  = FC_W'(FPS - 1);

  logic [HCOUNT_W-1:0] hcount_q, hcount_d;
  logic [VCOUNT_W-1:0] vcount_q, vcount_d;
  logic [FC_W-1:0]     fc_q, fc_d;
  logic                hs_raw, vs_raw, ad_raw, nf_raw;
  sync_bits_t          sync_now, sync_dly;

  // Raw decodes straight from the counter registers
  always_comb begin
    ad_raw = (hcount_q < H_ACT) && (vcount_q < V_ACT);
    hs_raw = (hcount_q >= HS_START) && (hcount_q <= HS_END);
    vs_raw = (vcount_q >= VS_START) && (vcount_q <= VS_END);
    nf_raw = (hcount_q == H_ACT) && (vcount_q == V_ACT);
  end

  // Counter next-state: pixel wrap advances the line, line wrap shares the same edge;
  // the frame counter advances on the edge that ends the new-frame cycle
  always_comb begin
    hcount_d = hcount_q + 1'b1;
    vcount_d = vcount_q;
    fc_d     = fc_q;
    if (hcount_q == H_LAST) begin
      hcount_d = '0;
      vcount_d = (vcount_q == V_LAST) ? '0 : vcount_q + 1'b1;
    end
    if (nf_raw) begin
      fc_d = (fc_q == FC_LAST) ? '0 : fc_q + 1'b1;
    end
  end

  // Counter registers; reset restarts the raster with no partial-line completion
  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      hcount_q <= '0;
      vcount_q <= '0;
      fc_q     <= '0;
    end else begin
      hcount_q <= hcount_d;
      vcount_q <= vcount_d;
      fc_q     <= fc_d;
    end
  end

  // Strobes are held low for the whole time reset is asserted
  always_comb begin
    sync_now.hs = hs_raw & ~rst_in;
    sync_now.vs = vs_raw & ~rst_in;
    sync_now.ad = ad_raw & ~rst_in;
  end

  sync_delay #(
    .WIDTH (3),
    .DEPTH (LATENCY)
  ) u_sync_delay (
    .clk_i (pixel_clk_in),
    .clr_i (rst_in),
    .d_i   (sync_now),
    .q_o   (sync_dly)
  );

  assign vid.hcount_out = hcount_q;
  assign vid.vcount_out = vcount_q;
  assign vid.fc_out     = fc_q;
  assign vid.hs_out     = sync_now.hs;
  assign vid.vs_out     = sync_now.vs;
  assign vid.ad_out     = sync_now.ad;
  assign vid.nf_out     = nf_raw & ~rst_in;
  assign vid.hs_d_out   = sync_dly.hs;
  assign vid.vs_d_out   = sync_dly.vs;
  assign vid.ad_d_out   = sync_dly.ad;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen using a reduced raster so 61 frames fit in a
// short run. Two instances (LATENCY 4 and 1) share clock and reset; their
// outputs are compared every cycle against an arithmetic model of the raster.
module tb_video_timing_gen;

  localparam int AH = 16, HFP = 3, HSW = 4, HBP = 5;
  localparam int AV = 10, VFP = 2, VSW = 2, VBP = 3;
  localparam int FPS = 60;
  localparam int TH = AH + HFP + HSW + HBP;   // 28
  localparam int TV = AV + VFP + VSW + VBP;   // 17
  localparam int FRAME = TH * TV;             // 476
  localparam int NF_AT = AV * TH + AH;        // cycles from release to first nf

  // ---------------- clock / reset ----------------
  logic pixel_clk_in = 1'b0;
  logic rst_in       = 1'b1;
  always #5 pixel_clk_in = ~pixel_clk_in;

  video_timing_gen_if vid4 ();
  video_timing_gen_if vid1 ();

  video_timing_gen #(
    .ACTIVE_H (AH), .H_FP (HFP), .H_SYNC (HSW), .H_BP (HBP),
    .ACTIVE_V (AV), .V_FP (VFP), .V_SYNC (VSW), .V_BP (VBP),
    .FPS (FPS), .LATENCY (4)
  ) dut4 (
    .pixel_clk_in (pixel_clk_in),
    .rst_in       (rst_in),
    .vid          (vid4)
  );

  video_timing_gen #(
    .ACTIVE_H (AH), .H_FP (HFP), .H_SYNC (HSW), .H_BP (HBP),
    .ACTIVE_V (AV), .V_FP (VFP), .V_SYNC (VSW), .V_BP (VBP),
    .FPS (FPS), .LATENCY (1)
  ) dut1 (
    .pixel_clk_in (pixel_clk_in),
    .rst_in       (rst_in),
    .vid          (vid1)
  );

  // ---------------- reference model ----------------
  int n;                       // clock edges since the last reset edge
  logic [2:0] exp_q4[$];       // expected {hs,vs,ad} history, depth 4
  logic [2:0] exp_q1[$];       // expected {hs,vs,ad} history, depth 1
  int vectors     = 0;
  int miscompares = 0;
  logic obs_nf;

  function automatic logic [2:0] ref_sync(int c);
    int h = c % TH;
    int v = (c / TH) % TV;
    logic hs = (h >= AH + HFP) && (h < AH + HFP + HSW);
    logic vs = (v >= AV + VFP) && (v < AV + VFP + VSW);
    logic ad = (h < AH) && (v < AV);
    return {hs, vs, ad};
  endfunction

  function automatic logic ref_nf(int c);
    return ((c % TH) == AH) && (((c / TH) % TV) == AV);
  endfunction

  // Frame count = number of nf cycles already completed, modulo FPS
  function automatic int ref_fc(int c);
    int frames = (c > NF_AT) ? ((c - NF_AT - 1) / FRAME + 1) : 0;
    return frames % FPS;
  endfunction

  task automatic flush_model();
    exp_q4 = {};
    exp_q1 = {};
    repeat (4) exp_q4.push_back(3'b000);
    exp_q1.push_back(3'b000);
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h (n=%0d)", tag, got, exp, n);
    end
  endtask

  // ---------------- driver ----------------
  // Called at posedge+1: drives rst for this cycle, checks, then advances one edge
  task automatic cycle(input logic r);
    logic [2:0] u;
    rst_in = r;
    #1;
    u = r ? 3'b000 : ref_sync(n);
    obs_nf = vid4.nf_out;
    check("hcount4", 32'(vid4.hcount_out), 32'(n % TH));
    check("vcount4", 32'(vid4.vcount_out), 32'((n / TH) % TV));
    check("fc4",     32'(vid4.fc_out),     32'(ref_fc(n)));
    check("sync4",   32'({vid4.hs_out, vid4.vs_out, vid4.ad_out}), 32'(u));
    check("nf4",     32'(vid4.nf_out),     32'(r ? 1'b0 : ref_nf(n)));
    check("sync_d4", 32'({vid4.hs_d_out, vid4.vs_d_out, vid4.ad_d_out}), 32'(exp_q4[0]));
    check("count1",  32'({vid1.fc_out, vid1.vcount_out, vid1.hcount_out}),
          32'({6'(ref_fc(n)), 10'((n / TH) % TV), 11'(n % TH)}));
    check("sync1",   32'({vid1.nf_out, vid1.hs_out, vid1.vs_out, vid1.ad_out}),
          32'({(r ? 1'b0 : ref_nf(n)), u}));
    check("sync_d1", 32'({vid1.hs_d_out, vid1.vs_d_out, vid1.ad_d_out}), 32'(exp_q1[0]));
    @(posedge pixel_clk_in);
    #1;
    if (r) begin
      n = 0;
      flush_model();
    end else begin
      n++;
      exp_q4.push_back(u);
      void'(exp_q4.pop_front());
      exp_q1.push_back(u);
      void'(exp_q1.pop_front());
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int guard;
    int k;
    n = 0;
    obs_nf = 1'b0;
    flush_model();
    rst_in = 1'b1;
    @(posedge pixel_clk_in);
    #1;

    // Reset held: strobes forced low, counters at 0
    repeat (2) cycle(1'b1);

    // 61 frames free-running: every line/frame/fc boundary incl. fc wrap 59->0
    repeat (61 * FRAME + 10) cycle(1'b0);

    // Mid-frame reset at (h=9, v=5) for 3 cycles
    guard = 0;
    while (!(((n % TH) == 9) && (((n / TH) % TV) == 5)) && guard < FRAME) begin
      cycle(1'b0);
      guard++;
    end
    check("reach_mid_frame", 32'(guard < FRAME), 32'd1);
    repeat (3) cycle(1'b1);

    // Next nf must come NF_AT cycles after release
    for (k = 0; k < 2 * FRAME; k++) begin
      cycle(1'b0);
      if (obs_nf) break;
    end
    check("nf_after_release", 32'(k), 32'(NF_AT));

    // Randomized run lengths and reset pulses
    repeat (6) begin
      repeat ($urandom_range(1, 2 * FRAME)) cycle(1'b0);
      repeat ($urandom_range(1, 4)) cycle(1'b1);
    end
    repeat (FRAME + 5) cycle(1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
- Generates 1280x720@60 raster timing: hcount/vcount, hsync/vsync, active-draw, new-frame strobe, frame counter.
- Sits directly upstream of the sprite/BRAM lookup stages, which consume hcount_out/vcount_out.
- Also emits copies of hsync/vsync/active-draw delayed by LATENCY cycles, matching the downstream 4-cycle BRAM pipeline so sync and pixel data stay aligned at the TMDS encoder.

Parameters:
- ACTIVE_H, 1280, active pixels per line
- H_FP, 110, horizontal front porch (pixels)
- H_SYNC, 40, horizontal sync width
- H_BP, 220, horizontal back porch
- ACTIVE_V, 720, active lines per frame
- V_FP, 5, vertical front porch (lines)
- V_SYNC, 5, vertical sync width
- V_BP, 20, vertical back porch
- FPS, 60, frame counter modulus
- LATENCY, 4, delay in cycles applied to the *_d_out copies (range 1..8)

Ports:
- pixel_clk_in  in  1  pixel clock (74.25 MHz)
- rst_in  in  1  synchronous active-high reset
- hcount_out  out  11  pixel column, 0..TOTAL_H-1
- vcount_out  out  10  line number, 0..TOTAL_V-1
- hs_out  out  1  hsync, active high
- vs_out  out  1  vsync, active high
- ad_out  out  1  active draw
- nf_out  out  1  new-frame pulse, one cycle
- fc_out  out  6  frame count, 0..FPS-1
- hs_d_out  out  1  hs_out delayed LATENCY cycles
- vs_d_out  out  1  vs_out delayed LATENCY cycles
- ad_d_out  out  1  ad_out delayed LATENCY cycles

Behaviour:
- Derived constants: TOTAL_H = ACTIVE_H+H_FP+H_SYNC+H_BP = 1650; TOTAL_V = 750.
- Reset: when rst_in is sampled high, hcount=0, vcount=0, fc=0, and every delay-pipe stage=0.
  - While rst_in is high, hs_out, vs_out, ad_out and nf_out are forced to 0.
- Counting: hcount increments by 1 each cycle. At TOTAL_H-1 it wraps to 0 and vcount increments.
  - vcount wraps from TOTAL_V-1 to 0 on the same cycle that hcount wraps.
- Decodes are combinational from the counter registers and consistent with hcount_out/vcount_out in the same cycle:
  - ad_out = (hcount < ACTIVE_H) && (vcount < ACTIVE_V)
  - hs_out = hcount in [ACTIVE_H+H_FP, ACTIVE_H+H_FP+H_SYNC-1], i.e. 1390..1429
  - vs_out = vcount in [ACTIVE_V+V_FP, ACTIVE_V+V_FP+V_SYNC-1], i.e. 725..729, for the whole line regardless of hcount
  - nf_out = (hcount == ACTIVE_H) && (vcount == ACTIVE_V): exactly one cycle per frame, the first blanking pixel after the last active line.
- Frame counter: fc increments on the clock edge ending the nf_out cycle, so the new value is visible the cycle after nf_out. It wraps FPS-1 -> 0.
- Delay pipes: *_d_out(t) = *_out(t-LATENCY). The first LATENCY cycles after reset release output 0.
- Reset mid-frame: counters return to 0 on the next edge with no partial-line completion. Delay pipes are flushed.
- Widths: all comparisons are done at counter width. Parameters must satisfy TOTAL_H <= 2048 and TOTAL_V <= 1024; this is checked at elaboration.

Decomposition:
- Package video_timing_pkg holds the 720p default constants (ACTIVE_H, porches, TOTAL_H, TOTAL_V) for reuse by the sprite and encoder stages.
- Sub-module sync_delay (parameter WIDTH, DEPTH) is a generic shift-register pipe with synchronous clear. It is instantiated once with WIDTH=3 for {hs, vs, ad}.

Test Plan:
- Reset release: after reset, hcount=0, vcount=0, ad_out=1 on the first cycle; ad_out=0 and hs_out=0 while rst_in=1.
- Line timing: ad_out falls at hcount=1280; hs_out is high for exactly 40 cycles from hcount=1390; hcount wraps 1649->0 with vcount 0->1.
- Frame timing: vs_out is high for lines 725..729 (8250 cycles); nf_out is a single pulse at (1280,720); period is 1,237,500 cycles.
- Frame counter: run 61 frames; fc_out goes 0->59 then returns to 0; fc_out updates the cycle after nf_out.
- Delay alignment: for LATENCY=4, hs_d_out, vs_d_out and ad_d_out equal the 4-cycle-old hs_out, vs_out and ad_out on every cycle across a full frame; also repeat with LATENCY=1.
- Mid-frame reset: assert rst_in at (hcount=700, vcount=300) for 3 cycles; counters return to 0,0, *_d_out stay 0 for 4 cycles after release, and the next nf_out arrives 1280+720*1650 cycles after release.
